dmem_arbiter: RTL and testbench

//  Arbitrates the single-port 1024x32 data memory between the pipeline MEM stage (core port) and
//  an auxiliary requester (debug/loader port). One access per cycle, synchronous 1-cycle read

---
 rtl/dmem_pkg.sv | 12 +
 rtl/dmem_arbiter_if.sv | 37 +++
 rtl/dmem_arb_pick.sv | 44 ++++
 rtl/dmem_arbiter.sv | 100 ++++++++++
 tb/tb_dmem_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: response tag, port ids, RAM depth.
package dmem_pkg;
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CORE = 2'd1,
        TAG_AUX  = 2'd2
    } resp_tag_e;

    localparam logic PORT_CORE  = 1'b0;
    localparam logic PORT_AUX   = 1'b1;
    localparam int   DMEM_WORDS = 1024;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core/aux requesters, the arbiter and the data RAM.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              c_req, c_we, c_gnt, c_stall, c_rvalid, c_err;
    logic [31:0]       c_addr;
    logic [DATA_W-1:0] c_wdata, c_rdata;

    logic              a_req, a_we, a_gnt, a_stall, a_rvalid, a_err;
    logic [31:0]       a_addr;
    logic [DATA_W-1:0] a_wdata, a_rdata;

    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    // arbiter side
    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  a_req, a_we, a_addr, a_wdata,
        input  mem_rdata,
        output c_gnt, c_stall, c_rvalid, c_rdata, c_err,
        output a_gnt, a_stall, a_rvalid, a_rdata, a_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // requesters + RAM side
    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output a_req, a_we, a_addr, a_wdata,
        output mem_rdata,
        input  c_gnt, c_stall, c_rvalid, c_rdata, c_err,
        input  a_gnt, a_stall, a_rvalid, a_rdata, a_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arb_pick.sv
// Pure grant selection between core and aux. DMEM_ARB_RR_EN selects strict
// round-robin; otherwise core priority with a starvation limit for aux.
module dmem_arb_pick
    import dmem_pkg::*;
#(
    parameter int CNT_W      = 3,
    parameter int STARVE_LIM = 4
) (
    input  logic             c_req,
    input  logic             a_req,
    input  logic             last_gnt,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             gnt_c,
    output logic             gnt_a
);
`ifdef DMEM_ARB_RR_EN
    logic unused_starve;
    assign unused_starve = ^starve_cnt;

    always_comb begin
        gnt_c = 1'b0;
        gnt_a = 1'b0;
        if (c_req && a_req) begin
            gnt_a = (last_gnt == PORT_CORE);
            gnt_c = ~gnt_a;
        end else begin
            gnt_c = c_req;
            gnt_a = a_req;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_gnt;

    always_comb begin
        gnt_c = 1'b0;
        gnt_a = 1'b0;
        if (a_req && (!c_req || starve_cnt == CNT_W'(STARVE_LIM)))
            gnt_a = 1'b1;
        else
            gnt_c = c_req;
    end
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter (core vs aux), 1-cycle read latency, error
// response on misaligned/out-of-range addresses. Build option: DMEM_ARB_RR_EN.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic           clk,
    input  logic           rst_,
    dmem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(STARVE_LIM + 1);

    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              last_gnt_q, last_gnt_d;
    resp_tag_e         tag_q, tag_d;
    logic              rsp_q, rsp_d;
    logic              err_q, err_d;

    logic              gnt_c, gnt_a, any_gnt;
    logic              win_we, addr_err;
    logic [31:0]       win_addr;
    logic [DATA_W-1:0] win_wdata;

    dmem_arb_pick #(.CNT_W(CNT_W), .STARVE_LIM(STARVE_LIM)) u_pick (
        .c_req      (bus.c_req),
        .a_req      (bus.a_req),
        .last_gnt   (last_gnt_q),
        .starve_cnt (starve_cnt_q),
        .gnt_c      (gnt_c),
        .gnt_a      (gnt_a)
    );

    // grants are held low while reset is asserted so nothing reaches the RAM
    assign bus.c_gnt   = gnt_c & rst_;
    assign bus.a_gnt   = gnt_a & rst_;
    assign bus.c_stall = bus.c_req & rst_ & ~bus.c_gnt;
    assign bus.a_stall = bus.a_req & rst_ & ~bus.a_gnt;
    assign any_gnt     = bus.c_gnt | bus.a_gnt;

    always_comb begin
        win_we    = gnt_a ? bus.a_we    : bus.c_we;
        win_addr  = gnt_a ? bus.a_addr  : bus.c_addr;
        win_wdata = gnt_a ? bus.a_wdata : bus.c_wdata;
    end

    assign addr_err      = (|win_addr[1:0]) | (|win_addr[31:ADDR_W+2]);
    assign bus.mem_en    = any_gnt & ~addr_err;
    assign bus.mem_we    = bus.mem_en & win_we;
    assign bus.mem_addr  = win_addr[ADDR_W+1:2];
    assign bus.mem_wdata = win_wdata;

    always_comb begin
        tag_d = TAG_NONE;
        if (bus.a_gnt)      tag_d = TAG_AUX;
        else if (bus.c_gnt) tag_d = TAG_CORE;
        // only reads and errors produce a response beat
        rsp_d = any_gnt & (addr_err | ~win_we);
        err_d = any_gnt & addr_err;

        last_gnt_d = last_gnt_q;
        if (bus.a_gnt)      last_gnt_d = PORT_AUX;
        else if (bus.c_gnt) last_gnt_d = PORT_CORE;

`ifdef DMEM_ARB_RR_EN
        starve_cnt_d = '0;
`else
        starve_cnt_d = starve_cnt_q;
        if (!bus.a_req || bus.a_gnt)
            starve_cnt_d = '0;
        else if (bus.c_gnt && starve_cnt_q != CNT_W'(STARVE_LIM))
            starve_cnt_d = starve_cnt_q + 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            tag_q        <= TAG_NONE;
            rsp_q        <= 1'b0;
            err_q        <= 1'b0;
            last_gnt_q   <= PORT_CORE;
            starve_cnt_q <= '0;
        end else begin
            tag_q        <= tag_d;
            rsp_q        <= rsp_d;
            err_q        <= err_d;
            last_gnt_q   <= last_gnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign bus.c_rvalid = (tag_q == TAG_CORE) & rsp_q;
    assign bus.a_rvalid = (tag_q == TAG_AUX)  & rsp_q;
    assign bus.c_err    = bus.c_rvalid & err_q;
    assign bus.a_err    = bus.a_rvalid & err_q;
    assign bus.c_rdata  = (bus.c_rvalid & ~err_q) ? bus.mem_rdata : '0;
    assign bus.a_rdata  = (bus.a_rvalid & ~err_q) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a request-level model (honours DMEM_ARB_RR_EN).
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int STARVE_LIM = 4;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(STARVE_LIM)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    // RAM attached to the DUT's memory port
    logic [DATA_W-1:0] ram     [DMEM_WORDS];
    // expected RAM contents, updated only from model decisions
    logic [DATA_W-1:0] mdl_mem [DMEM_WORDS];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int          m_starve = 0;   // core grants in a row while aux kept asking
    int          m_last   = 0;   // 0 core, 1 aux
    int          m_rsp    = -1;  // port owed a response this cycle, -1 none
    logic [31:0] m_rdata;
    bit          m_rerr;
    int          m_win;
    logic [31:0] m_addr;
    logic [31:0] m_wd;
    bit          m_we;
    bit          m_err;

    always @(negedge clk) begin
        if (!rst_) begin
            chk("rst c_gnt",    bus.c_gnt, 0);
            chk("rst a_gnt",    bus.a_gnt, 0);
            chk("rst c_stall",  bus.c_stall, 0);
            chk("rst a_stall",  bus.a_stall, 0);
            chk("rst mem_en",   bus.mem_en, 0);
            chk("rst mem_we",   bus.mem_we, 0);
            chk("rst c_rvalid", bus.c_rvalid, 0);
            chk("rst a_rvalid", bus.a_rvalid, 0);
            chk("rst c_err",    bus.c_err, 0);
            chk("rst a_err",    bus.a_err, 0);
            chk("rst c_rdata",  bus.c_rdata, 0);
            chk("rst a_rdata",  bus.a_rdata, 0);
            m_starve = 0;
            m_last   = 0;
            m_rsp    = -1;
        end else begin
            m_win = -1;
`ifdef DMEM_ARB_RR_EN
            if (bus.c_req && bus.a_req) m_win = (m_last == 0) ? 1 : 0;
            else if (bus.c_req)         m_win = 0;
            else if (bus.a_req)         m_win = 1;
`else
            if (bus.a_req && (!bus.c_req || m_starve == STARVE_LIM)) m_win = 1;
            else if (bus.c_req)                                       m_win = 0;
`endif
            chk("c_gnt",   bus.c_gnt, m_win == 0);
            chk("a_gnt",   bus.a_gnt, m_win == 1);
            chk("c_stall", bus.c_stall, bus.c_req && m_win != 0);
            chk("a_stall", bus.a_stall, bus.a_req && m_win != 1);

            if (m_win >= 0) begin
                m_addr = (m_win == 1) ? bus.a_addr  : bus.c_addr;
                m_we   = (m_win == 1) ? bus.a_we    : bus.c_we;
                m_wd   = (m_win == 1) ? bus.a_wdata : bus.c_wdata;
                m_err  = (m_addr % 4 != 0) || (m_addr >= 4 * DMEM_WORDS);
                chk("mem_en", bus.mem_en, !m_err);
                if (!m_err) begin
                    chk("mem_we",   bus.mem_we, m_we);
                    chk("mem_addr", bus.mem_addr, m_addr / 4);
                    if (m_we) chk("mem_wdata", bus.mem_wdata, m_wd);
                end
            end else begin
                chk("mem_en idle", bus.mem_en, 0);
            end

            chk("c_rvalid", bus.c_rvalid, m_rsp == 0);
            chk("a_rvalid", bus.a_rvalid, m_rsp == 1);
            chk("c_err",    bus.c_err,    m_rsp == 0 && m_rerr);
            chk("a_err",    bus.a_err,    m_rsp == 1 && m_rerr);
            chk("c_rdata",  bus.c_rdata,  (m_rsp == 0) ? m_rdata : 32'h0);
            chk("a_rdata",  bus.a_rdata,  (m_rsp == 1) ? m_rdata : 32'h0);

            m_rsp = -1;
            if (m_win >= 0) begin
                if (m_err || !m_we) begin
                    m_rsp   = m_win;
                    m_rerr  = m_err;
                    m_rdata = m_err ? 32'h0 : mdl_mem[m_addr / 4];
                end
                if (!m_err && m_we) mdl_mem[m_addr / 4] = m_wd;
                m_last = m_win;
            end
            if (!bus.a_req || m_win == 1)                m_starve = 0;
            else if (m_win == 0 && m_starve < STARVE_LIM) m_starve++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                         input bit ar, input bit aw, input logic [31:0] aa, input logic [31:0] ad);
        @(posedge clk); #1;
        bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
        bus.a_req = ar; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
    endtask

    task automatic idle();
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        idle();
        rst_ = 1'b0;
        @(posedge clk); #1;
        rst_ = 1'b1;
    endtask

    function automatic logic [31:0] rnd_addr();
        int unsigned r;
        r = $urandom_range(0, 19);
        if (r == 0) return ($urandom_range(0, 63) << 2) | $urandom_range(1, 3);
        if (r == 1) return $urandom | 32'h0000_1000;
        return $urandom_range(0, 15) << 2;
    endfunction

    logic [9:0] seq, stl, exp_pat;
    bit cg, ag;

    initial begin
        for (int i = 0; i < DMEM_WORDS; i++) begin
            ram[i]     = i * 32'h9E37_79B9;
            mdl_mem[i] = i * 32'h9E37_79B9;
        end
        ram[4]     = 32'hDEAD_BEEF;
        mdl_mem[4] = 32'hDEAD_BEEF;
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
        repeat (2) @(posedge clk);
        #1 rst_ = 1'b1;

        // core read of word 4
        drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        #3;
        chk("t1 c_gnt", bus.c_gnt, 1);
        chk("t1 mem_en", bus.mem_en, 1);
        chk("t1 mem_addr", bus.mem_addr, 4);
        idle(); #3;
        chk("t1 c_rvalid", bus.c_rvalid, 1);
        chk("t1 c_rdata", bus.c_rdata, 32'hDEAD_BEEF);
        chk("t1 a_rvalid", bus.a_rvalid, 0);

        // aux write then core read of the same word
        drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h8, 32'h1234);
        #3 chk("t4 a_gnt", bus.a_gnt, 1);
        drive(1, 0, 32'h8, 32'h0, 0, 0, 32'h0, 32'h0);
        idle(); #3;
        chk("t4 c_rvalid", bus.c_rvalid, 1);
        chk("t4 c_rdata", bus.c_rdata, 32'h1234);

        // misaligned and out-of-range core reads
        drive(1, 0, 32'h6, 32'h0, 0, 0, 32'h0, 32'h0);
        #3 chk("t5 mem_en a", bus.mem_en, 0);
        chk("t5 c_gnt a", bus.c_gnt, 1);
        drive(1, 0, 32'h1000, 32'h0, 0, 0, 32'h0, 32'h0);
        #3 chk("t5 mem_en b", bus.mem_en, 0);
        chk("t5 c_err a", bus.c_err, 1);
        chk("t5 c_rdata a", bus.c_rdata, 0);
        idle(); #3;
        chk("t5 c_rvalid b", bus.c_rvalid, 1);
        chk("t5 c_err b", bus.c_err, 1);
        chk("t5 c_rdata b", bus.c_rdata, 0);

        // both requesting continuously from a fresh reset
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 32'h20, 32'h0, 1, 0, 32'h24, 32'h0);
            #3;
            seq[i] = bus.a_gnt;
            stl[i] = bus.c_stall;
        end
`ifdef DMEM_ARB_RR_EN
        exp_pat = 10'b01_0101_0101;
`else
        exp_pat = 10'b10_0001_0000;
`endif
        chk("t2 grant pattern", seq, exp_pat);
        chk("t2 core stall pattern", stl, exp_pat);
        idle();

        // reset between grant and response
        drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        #2 rst_ = 1'b0;
        #1;
        chk("t6 c_gnt in reset", bus.c_gnt, 0);
        chk("t6 c_stall in reset", bus.c_stall, 0);
        chk("t6 mem_en in reset", bus.mem_en, 0);
        @(posedge clk); #1;
        bus.c_req = 0;
        rst_ = 1'b1;
        #3;
        chk("t6 c_rvalid after", bus.c_rvalid, 0);
        chk("t6 c_rdata after", bus.c_rdata, 0);

        // randomized traffic; requests held until granted
        cg = 1; ag = 1;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            if (!bus.c_req || cg) begin
                bus.c_req = ($urandom_range(0, 9) < 7);
                bus.c_we = 1'($urandom_range(0, 1));
                bus.c_addr = rnd_addr();
                bus.c_wdata = $urandom;
            end
            if (!bus.a_req || ag) begin
                bus.a_req = ($urandom_range(0, 9) < 6);
                bus.a_we = 1'($urandom_range(0, 1));
                bus.a_addr = rnd_addr();
                bus.a_wdata = $urandom;
            end
            #3;
            cg = bus.c_gnt;
            ag = bus.a_gnt;
        end
        idle();
        idle();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
